mac_operand_loader: RTL and testbench
=====================================

// Module: mac_operand_loader
// PURPOSE
//  Upstream feeder for the 4-tap MAC stage. Accepts a stream of (a,b) operand pairs over a
//  valid/ready handshake and packs TAPS pairs into one operand vector. It presents each vector
//  to the MAC as flattened A/B buses with its own valid/ready handshake.
//  Two ping-pong banks let the next vector fill while the MAC still holds the current one.
// PARAMETERS
//  DATA_W   4   width of each a/b operand (MAC product is 2*DATA_W)
//  TAPS     4   pairs per vector; power of two, >=2
//  CNT_W    8   width of delivered-vector counter
// PORTS
//  cp         in   1              clock, rising edge
//  rst_n      in   1              asynchronous active-low reset
//  in_valid   in   1              in_a/in_b/in_last valid this cycle
//  in_ready   out  1              loader can accept a pair this cycle
//  in_a       in   DATA_W         operand A element
//  in_b       in   DATA_W         operand B element
//  in_last    in   1              pair closes the vector early; remaining slots zero-filled
//  out_valid  out  1              out_a/out_b hold a complete vector
//  out_ready  in   1              MAC consumes vector this cycle
//  out_a      out  TAPS*DATA_W    slot k at [k*DATA_W +: DATA_W]
//  out_b      out  TAPS*DATA_W    same packing as out_a
//  vec_count  out  CNT_W          vectors delivered since reset; wraps at 2**CNT_W
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low. While rst_n=0, both banks clear to 0,
//   both full flags clear, wr_bank=rd_bank=0, idx=0, vec_count=0 -> out_valid=0, in_ready=1,
//   out_a=out_b=0. Asserting rst_n mid-vector discards any partial and any held vectors.
//  Fill side: idx (0..TAPS-1) addresses the next slot of bank wr_bank.
//   in_ready = !full[wr_bank]. It is a pure function of registers; out_ready has no
//   combinational path to it.
//   Accept = in_valid & in_ready: slot idx <= (in_a,in_b).
//   If idx==TAPS-1 or in_last: slots idx+1..TAPS-1 <= 0 (zero pairs add nothing to the MAC sum),
//   full[wr_bank] <= 1, wr_bank toggles, idx <= 0. Otherwise idx <= idx+1.
//   in_last at idx==TAPS-1 is identical to a normal final pair.
//   in_valid without in_ready: nothing is written; the pair must be held by the sender.
//  Drain side: out_valid = full[rd_bank]; out_a/out_b are driven from bank rd_bank.
//   Release = out_valid & out_ready: full[rd_bank] <= 0, rd_bank toggles,
//   vec_count <= vec_count+1 (mod 2**CNT_W).
//   While out_valid=1 and out_ready=0, out_a/out_b/out_valid are held stable.
//   out_ready while out_valid=0 has no effect.
//  Latency: the closing pair accepted at edge n gives out_valid=1 from edge n (empty drain side).
//   Sustained rate: one pair per cycle, one vector per TAPS cycles.
//  Both banks full: in_ready=0. A release at edge n gives in_ready=1 from edge n. No pair is dropped.
//  Simultaneous close of bank X and release of bank Y in one edge: both take effect.
//   Closing into the bank being released in the same edge cannot occur, because in_ready=0
//   whenever that bank is full.
//  Bank contents are never read combinationally from in_* (no input-to-output bypass).
// TESTING
//  T1 reset: rst_n=0 mid-stream with 2 pairs loaded -> out_valid=0, in_ready=1, vec_count=0;
//     the next 4 pairs form a clean vector.
//  T2 single vector: pairs (1,2)(3,4)(5,6)(7,8), out_ready=1 -> one out_valid pulse,
//     out_a=0x7531, out_b=0x8642, vec_count=1.
//  T3 early close: (15,15) then (2,3) with in_last -> out_a=0x002F, out_b=0x003F
//     (slots 2,3 zero).
//  T4 backpressure: out_ready=0, in_valid=1, 12 pairs offered -> exactly 8 accepted, then
//     in_ready=0; out_a stable. Raise out_ready -> vectors delivered in order, none lost.
//  T5 streaming: 64 pairs back-to-back, out_ready=1 -> in_ready never drops, 16 vectors,
//     vec_count=16.
//  T6 wrap: deliver 256 vectors -> vec_count returns to 0.

Source files
------------

// File: rtl/mac_operand_loader.sv
// Packs TAPS (a,b) operand pairs into one vector for the MAC stage, using two
// ping-pong banks so the next vector can fill while the MAC holds the current one.
module mac_operand_loader #(
   parameter int DATA_W = 4,
   parameter int TAPS   = 4,
   parameter int CNT_W  = 8
) (
   input  logic                     cp,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_a,
   input  logic [DATA_W-1:0]        in_b,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TAPS*DATA_W-1:0]   out_a,
   output logic [TAPS*DATA_W-1:0]   out_b,
   output logic [CNT_W-1:0]         vec_count
);
   localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

   logic [1:0][TAPS-1:0][DATA_W-1:0] bank_a_q, bank_a_d;
   logic [1:0][TAPS-1:0][DATA_W-1:0] bank_b_q, bank_b_d;
   logic [1:0]                       full_q, full_d;
   logic                             wr_bank_q, wr_bank_d;
   logic                             rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0]                 idx_q, idx_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;

   logic accept, close, release_v;

   always_comb begin
      in_ready  = !full_q[wr_bank_q];
      out_valid = full_q[rd_bank_q];
      out_a     = bank_a_q[rd_bank_q];
      out_b     = bank_b_q[rd_bank_q];
      vec_count = cnt_q;

      accept    = in_valid & in_ready;
      close     = accept & (in_last | (idx_q == IDX_W'(TAPS-1)));
      release_v = out_valid & out_ready;

      bank_a_d  = bank_a_q;
      bank_b_d  = bank_b_q;
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;

      // Slots past the closing pair are zeroed so a short vector adds nothing to the sum.
      for (int k = 0; k < TAPS; k++) begin
         if (accept && IDX_W'(k) == idx_q) begin
            bank_a_d[wr_bank_q][k] = in_a;
            bank_b_d[wr_bank_q][k] = in_b;
         end else if (close && IDX_W'(k) > idx_q) begin
            bank_a_d[wr_bank_q][k] = '0;
            bank_b_d[wr_bank_q][k] = '0;
         end
      end

      if (release_v) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
         cnt_d             = cnt_q + CNT_W'(1);
      end

      if (close) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
         idx_d             = '0;
      end else if (accept) begin
         idx_d = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge cp or negedge rst_n) begin
      if (!rst_n) begin
         bank_a_q  <= '0;
         bank_b_q  <= '0;
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         idx_q     <= '0;
         cnt_q     <= '0;
      end else begin
         bank_a_q  <= bank_a_d;
         bank_b_q  <= bank_b_d;
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule

// File: tb/tb_mac_operand_loader.sv
// Directed bench for mac_operand_loader: reset, packing, early close,
// backpressure, streaming and counter wrap.
module tb_mac_operand_loader;
   logic        cp = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_last;
   logic [3:0]  in_a, in_b;
   logic        out_valid, out_ready;
   logic [15:0] out_a, out_b;
   logic [7:0]  vec_count;

   int tests = 0;
   int fails = 0;

   mac_operand_loader #(.DATA_W(4), .TAPS(4), .CNT_W(8)) dut (
      .cp(cp), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .vec_count(vec_count)
   );

   always #5 cp = ~cp;

   task automatic tick();
      @(posedge cp);
      #1;
   endtask

   // Offer one pair until accepted; returns number of stalled cycles.
   task automatic push(input logic [3:0] a, input logic [3:0] b, input logic last,
                       output int stalls);
      stalls   = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      while (!in_ready && stalls < 50) begin
         tick();
         stalls++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
      end else
         tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Wait for a vector and consume it, returning its contents.
   task automatic pop(output logic [15:0] a, output logic [15:0] b);
      int w = 0;
      out_ready = 1'b1;
      while (!out_valid && w < 50) begin
         tick();
         w++;
      end
      if (!out_valid) begin
         tests++; fails++;
         $display("FAIL pop_timeout: out_valid=%0b required 1", out_valid);
      end
      a = out_a;
      b = out_b;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_state();
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (2) tick();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || vec_count !== 8'd0 ||
          out_a !== 16'h0 || out_b !== 16'h0) begin
         fails++;
         $display("FAIL reset_state: ov=%b ir=%b cnt=%0d a=%h b=%h required ov=0 ir=1 cnt=0 a=0 b=0",
                  out_valid, in_ready, vec_count, out_a, out_b);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_vector();
      int s;
      logic [7:0] c0;
      c0 = vec_count;
      out_ready = 1'b1;
      push(4'd1, 4'd2, 1'b0, s);
      push(4'd3, 4'd4, 1'b0, s);
      push(4'd5, 4'd6, 1'b0, s);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL single_early_valid: out_valid=%b required 0", out_valid);
      end
      push(4'd7, 4'd8, 1'b0, s);
      tests++;
      if (out_valid !== 1'b1 || out_a !== 16'h7531 || out_b !== 16'h8642) begin
         fails++;
         $display("FAIL single_data: ov=%b a=%h b=%h required ov=1 a=7531 b=8642", out_valid, out_a, out_b);
      end
      tick();
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || vec_count !== c0 + 8'd1) begin
         fails++;
         $display("FAIL single_release: ov=%b cnt=%0d required ov=0 cnt=%0d", out_valid, vec_count, c0 + 8'd1);
      end
   endtask

   task automatic test_early_close();
      int s;
      logic [15:0] a, b;
      push(4'd15, 4'd15, 1'b0, s);
      push(4'd2, 4'd3, 1'b1, s);
      tests++;
      if (out_valid !== 1'b1 || out_a !== 16'h002F || out_b !== 16'h003F) begin
         fails++;
         $display("FAIL early_close: ov=%b a=%h b=%h required ov=1 a=002f b=003f", out_valid, out_a, out_b);
      end
      pop(a, b);
      // The next full vector must start at slot 0 again.
      push(4'd1, 4'd1, 1'b0, s);
      push(4'd2, 4'd2, 1'b0, s);
      push(4'd3, 4'd3, 1'b0, s);
      push(4'd4, 4'd4, 1'b0, s);
      pop(a, b);
      tests++;
      if (a !== 16'h4321 || b !== 16'h4321) begin
         fails++; $display("FAIL after_early: a=%h b=%h required a=4321 b=4321", a, b);
      end
   endtask

   task automatic test_reset_midstream();
      int s;
      logic [15:0] a, b;
      out_ready = 1'b0;
      push(4'd1, 4'd1, 1'b0, s);
      push(4'd1, 4'd1, 1'b0, s);
      push(4'd1, 4'd1, 1'b0, s);
      push(4'd1, 4'd1, 1'b0, s);
      push(4'd5, 4'd5, 1'b0, s);
      push(4'd6, 4'd6, 1'b0, s);
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || vec_count !== 8'd0 || out_a !== 16'h0) begin
         fails++;
         $display("FAIL reset_mid: ov=%b ir=%b cnt=%0d a=%h required ov=0 ir=1 cnt=0 a=0",
                  out_valid, in_ready, vec_count, out_a);
      end
      tick();
      rst_n = 1'b1;
      tick();
      push(4'd9, 4'd1, 1'b0, s);
      push(4'd2, 4'd3, 1'b0, s);
      push(4'd4, 4'd5, 1'b0, s);
      push(4'd6, 4'd7, 1'b0, s);
      pop(a, b);
      tests++;
      if (a !== 16'h6429 || b !== 16'h7531 || vec_count !== 8'd1) begin
         fails++;
         $display("FAIL reset_clean_vec: a=%h b=%h cnt=%0d required a=6429 b=7531 cnt=1", a, b, vec_count);
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      logic [15:0] held, a, b;
      out_ready = 1'b0;
      held = '0;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1;
         in_a = 4'(acc + 1);
         in_b = 4'(15 - acc);
         in_last = 1'b0;
         if (in_ready) acc++;
         tick();
         if (acc == 4 && held == 16'h0) held = out_a;
      end
      in_valid = 1'b0;
      tests++;
      if (acc != 8 || in_ready !== 1'b0) begin
         fails++; $display("FAIL bp_accept: accepted=%0d ir=%b required 8 and 0", acc, in_ready);
      end
      tests++;
      if (held !== 16'h4321 || out_a !== 16'h4321) begin
         fails++; $display("FAIL bp_stable: first=%h now=%h required 4321", held, out_a);
      end
      pop(a, b);
      tests++;
      if (a !== 16'h4321 || b !== 16'hCDEF || in_ready !== 1'b1) begin
         fails++; $display("FAIL bp_vec0: a=%h b=%h ir=%b required 4321 cdef 1", a, b, in_ready);
      end
      pop(a, b);
      tests++;
      if (a !== 16'h8765 || b !== 16'h89AB || vec_count !== 8'd3) begin
         fails++; $display("FAIL bp_vec1: a=%h b=%h cnt=%0d required 8765 89ab 3", a, b, vec_count);
      end
   endtask

   task automatic test_streaming();
      int s, stalls = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         push(4'(i), 4'(i * 3), 1'b0, s);
         stalls += s;
         if (i < 63) in_valid = 1'b1;
      end
      tests++;
      if (stalls != 0) begin
         fails++; $display("FAIL stream_stalls: stalls=%0d required 0", stalls);
      end
      tests++;
      if (out_valid !== 1'b1 || out_a !== 16'hFEDC || out_b !== 16'hDA74) begin
         fails++;
         $display("FAIL stream_last: ov=%b a=%h b=%h required ov=1 a=fedc b=da74", out_valid, out_a, out_b);
      end
      tick();
      out_ready = 1'b0;
      tests++;
      if (vec_count !== 8'd19 || out_valid !== 1'b0) begin
         fails++; $display("FAIL stream_count: cnt=%0d ov=%b required 19 0", vec_count, out_valid);
      end
   endtask

   task automatic test_wrap();
      int s;
      int n;
      n = 256 - int'(vec_count);
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) push(4'd1, 4'd1, 1'b1, s);
      tests++;
      if (vec_count !== 8'd255) begin
         fails++; $display("FAIL wrap_pre: cnt=%0d required 255", vec_count);
      end
      tick();
      out_ready = 1'b0;
      tests++;
      if (vec_count !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL wrap: cnt=%0d ov=%b ir=%b required 0 0 1", vec_count, out_valid, in_ready);
      end
   endtask

   initial begin
      test_reset_state();
      test_single_vector();
      test_early_close();
      test_reset_midstream();
      test_backpressure();
      test_streaming();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
